// File: rtl/efcc_dropper_pkg.sv
// efcc_dropper_pkg: shared state encodings and class clamp for the frame class dropper
package efcc_dropper_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;
    localparam logic [1:0] ST_SWALLOW = 2'd3;

    function automatic int class_clamp(input int t, input int n);
        return (t >= n) ? n - 1 : t;
    endfunction
endpackage

// File: rtl/ethernet_frame_class_dropper_if.sv
// ethernet_frame_class_dropper_if: AXI4-Stream bundle (tdata/tkeep/tvalid/tready/tlast/tuser/tdest)
interface ethernet_frame_class_dropper_if #(
    parameter int DW = 8,
    parameter int KW = DW / 8,
    parameter int CW = 2
);
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;
    logic [CW-1:0] tdest;

    modport master(output tdata, tkeep, tvalid, tlast, tuser, tdest, input tready);
    modport slave(input tdata, tkeep, tvalid, tlast, tuser, tdest, output tready);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating counter; clr wins over inc. Ports: clk, rst, inc, clr, q
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (inc && !(&q)) q <= q + WIDTH'(1);
    end
endmodule

// File: rtl/ethernet_frame_class_dropper.sv
// ethernet_frame_class_dropper: per-class threshold frame dropper with optional truncation
// Ports: clk/rst; drop_enable, threshold, fifo_level, hard_limit, truncate_enable, stats_clear
// controls; drop_count/trunc_count statistics; s_axis (upstream slave), m_axis (downstream master)
module ethernet_frame_class_dropper
    import efcc_dropper_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int C_NUM_CLASSES      = 4,
    parameter int C_CLASS_WIDTH      = 2,
    parameter int C_LEVEL_WIDTH      = 16,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [C_NUM_CLASSES-1:0]               drop_enable,
    input  logic                                   truncate_enable,
    input  logic [C_LEVEL_WIDTH-1:0]               fifo_level,
    input  logic [C_NUM_CLASSES*C_LEVEL_WIDTH-1:0] threshold,
    input  logic [C_LEVEL_WIDTH-1:0]               hard_limit,
    input  logic                                   stats_clear,
    output logic [C_NUM_CLASSES*C_CNT_WIDTH-1:0]   drop_count,
    output logic [C_CNT_WIDTH-1:0]                 trunc_count,
    ethernet_frame_class_dropper_if.slave          s_axis,
    ethernet_frame_class_dropper_if.master         m_axis
);
    logic [1:0] state, state_n;
    logic trunc_req, acc_q, prev_stall, prev_trunc;
    logic [C_CLASS_WIDTH-1:0] tdest_in;
    logic [C_AXIS_TDATA_WIDTH-1:0] data_w;
    logic [C_AXIS_TKEEP_WIDTH-1:0] keep_w;
    logic [C_NUM_CLASSES-1:0] hit, drop_inc;
    logic idle_v, drop_now, trunc_act, s_acc, pass_acc;
    int c_in;

    assign tdest_in = s_axis.tdest;
    assign data_w   = s_axis.tdata;
    assign keep_w   = s_axis.tkeep;
    assign c_in     = class_clamp(32'(tdest_in), C_NUM_CLASSES);

    genvar k;
    for (k = 0; k < C_NUM_CLASSES; k++) begin : g_cls
        assign hit[k] = drop_enable[k] && (c_in == k) &&
                        (fifo_level >= threshold[k*C_LEVEL_WIDTH +: C_LEVEL_WIDTH]);
        sat_counter #(.WIDTH(C_CNT_WIDTH)) u_drop (
            .clk(clk), .rst(rst), .inc(drop_inc[k]), .clr(stats_clear),
            .q(drop_count[k*C_CNT_WIDTH +: C_CNT_WIDTH])
        );
    end

    assign idle_v   = (state == ST_IDLE) && s_axis.tvalid;
    assign drop_now = idle_v && (|hit);
    assign drop_inc = hit & {C_NUM_CLASSES{idle_v}};
    // A beat that was stalled last cycle keeps its shape; only a fresh beat (or the
    // already-truncated beat still waiting) carries the forced tlast/tuser.
    assign trunc_act = (state == ST_PASS) && trunc_req && (!prev_stall || prev_trunc);

    assign m_axis.tvalid = s_axis.tvalid && ((state == ST_PASS) || ((state == ST_IDLE) && !drop_now));
    assign s_axis.tready = (state == ST_DROP || state == ST_SWALLOW || drop_now) ? 1'b1 : m_axis.tready;
    assign m_axis.tdata  = data_w;
    assign m_axis.tkeep  = keep_w;
    assign m_axis.tdest  = s_axis.tdest;
    assign m_axis.tlast  = s_axis.tlast || trunc_act;
    assign m_axis.tuser  = s_axis.tuser || trunc_act;
    assign s_acc    = s_axis.tvalid && s_axis.tready;
    assign pass_acc = m_axis.tvalid && m_axis.tready;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (s_axis.tvalid)
                state_n = drop_now ? (s_axis.tlast ? ST_IDLE : ST_DROP)
                                   : ((pass_acc && s_axis.tlast) ? ST_IDLE : ST_PASS);
            ST_PASS: if (pass_acc && (s_axis.tlast || trunc_act))
                state_n = s_axis.tlast ? ST_IDLE : ST_SWALLOW;
            default: if (s_acc && s_axis.tlast) state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            trunc_req  <= 1'b0;
            acc_q      <= 1'b0;
            prev_stall <= 1'b0;
            prev_trunc <= 1'b0;
        end else begin
            state      <= state_n;
            acc_q      <= (state_n == ST_PASS) && (acc_q || pass_acc);
            prev_stall <= m_axis.tvalid && !m_axis.tready;
            prev_trunc <= trunc_act && m_axis.tvalid && !m_axis.tready;
            // Request lives only while the frame stays in PASS; leaving PASS clears it.
            trunc_req  <= (state_n == ST_PASS) && (trunc_req ||
                          ((state == ST_PASS) && truncate_enable && acc_q && (fifo_level >= hard_limit)));
        end
    end

    sat_counter #(.WIDTH(C_CNT_WIDTH)) u_trunc (
        .clk(clk), .rst(rst), .inc(trunc_act && pass_acc), .clr(stats_clear), .q(trunc_count)
    );
endmodule

// File: tb/tb_ethernet_frame_class_dropper.sv
// tb_ethernet_frame_class_dropper: scoreboard bench with a frame-level reference model
module tb_ethernet_frame_class_dropper;
    localparam int NC = 4, CW = 3, LW = 16, CNTW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0] drop_enable;
    logic truncate_enable, stats_clear;
    logic [LW-1:0] fifo_level, hard_limit;
    logic [NC*LW-1:0] threshold;
    logic [NC*CNTW-1:0] drop_count;
    logic [CNTW-1:0] trunc_count;

    always #5 clk = ~clk;

    ethernet_frame_class_dropper_if #(.DW(8), .KW(1), .CW(CW)) s_if ();
    ethernet_frame_class_dropper_if #(.DW(8), .KW(1), .CW(CW)) m_if ();

    ethernet_frame_class_dropper #(
        .C_AXIS_TDATA_WIDTH(8), .C_AXIS_TKEEP_WIDTH(1), .C_NUM_CLASSES(NC),
        .C_CLASS_WIDTH(CW), .C_LEVEL_WIDTH(LW), .C_CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .drop_enable(drop_enable), .truncate_enable(truncate_enable),
        .fifo_level(fifo_level), .threshold(threshold), .hard_limit(hard_limit),
        .stats_clear(stats_clear), .drop_count(drop_count), .trunc_count(trunc_count),
        .s_axis(s_if), .m_axis(m_if)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
        logic       u;
        logic [2:0] t;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0, failures = 0;
    int m_drop[NC];
    int m_trunc;
    int lvl_a[256], dat_a[256];
    bit kp_a[256], usr_a[256];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v);
        return v > 15 ? 15 : v;
    endfunction

    task automatic check_counts();
        for (int k = 0; k < NC; k++)
            check($sformatf("drop_count[%0d]", k), int'(drop_count[k*CNTW +: CNTW]), m_drop[k]);
        check("trunc_count", int'(trunc_count), m_trunc);
    endtask

    // Monitor: pops the scoreboard on every accepted output beat and checks that a
    // stalled beat stays valid and unchanged.
    initial begin
        beat_t cur, prev, e;
        logic pstall;
        pstall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, m_if.tdest};
            if (rst) pstall = 1'b0;
            else begin
                if (pstall) begin
                    check("hold_valid", int'(m_if.tvalid), 1);
                    check("hold_beat", int'(cur), int'(prev));
                end
                if (m_if.tvalid && m_if.tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=none at %0t", cur, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur != e) begin
                            failures++;
                            $display("FAIL out_beat actual=%0h required=%0h at %0t", cur, e, $time);
                        end
                    end
                end
                pstall = m_if.tvalid && !m_if.tready;
                prev = cur;
            end
        end
    end

    // Sends one frame from lvl_a/dat_a/kp_a/usr_a and pushes the reference outcome.
    task automatic send_frame(input int n, input int dest, input bit rnd, input int stall0, output int cyc);
        int c, tj, last_out, k;
        bit drop, acc;
        beat_t b;
        c = dest >= NC ? NC - 1 : dest;
        drop = drop_enable[c] && (lvl_a[0] >= int'(threshold[c*LW +: LW]));
        tj = -1;
        if (drop) m_drop[c] = sat(m_drop[c] + 1);
        else begin
            if (truncate_enable)
                for (int j = 1; j <= n - 2; j++)
                    if (tj < 0 && lvl_a[j] >= int'(hard_limit)) tj = j;
            last_out = tj >= 0 ? tj + 1 : n - 1;
            for (int i = 0; i <= last_out; i++) begin
                b = {8'(dat_a[i]), kp_a[i], i == last_out, usr_a[i] | (tj >= 0 && i == last_out), 3'(dest)};
                exp_q.push_back(b);
            end
            if (tj >= 0) m_trunc = sat(m_trunc + 1);
        end
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'(dat_a[i]);
            s_if.tkeep  = kp_a[i];
            s_if.tuser  = usr_a[i];
            s_if.tlast  = (i == n - 1);
            s_if.tdest  = 3'(dest);
            fifo_level  = 16'(lvl_a[i]);
            acc = 1'b0;
            k = 0;
            while (!acc) begin
                m_if.tready = (i == 0 && k < stall0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
                if (i == 0 && k > 0 && k <= stall0) fifo_level = 16'(lvl_a[0] + 4 * k);
                @(negedge clk);
                if (drop) begin
                    check("drop_tready", int'(s_if.tready), 1);
                    check("drop_tvalid", int'(m_if.tvalid), 0);
                end
                acc = s_if.tready;
                @(posedge clk);
                #1;
                k++;
                cyc++;
                if (k > 1000) begin
                    failures++;
                    $display("FAIL accept_timeout beat=%0d required=accepted", i);
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $fatal(1, "timeout");
                end
            end
        end
    endtask

    task automatic gap(input int n, input bit rnd);
        s_if.tvalid = 1'b0;
        repeat (n) begin
            m_if.tready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            lvl_a[i] = $urandom_range(lo, hi);
            dat_a[i] = $urandom_range(0, 255);
            kp_a[i]  = 1'($urandom_range(0, 1));
            usr_a[i] = ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        s_if.tvalid = 0; s_if.tdata = 0; s_if.tkeep = 0; s_if.tlast = 0; s_if.tuser = 0; s_if.tdest = 0;
        m_if.tready = 1'b1;
        drop_enable = '0; truncate_enable = 0; stats_clear = 0;
        fifo_level = 0; hard_limit = 16'hffff; threshold = {NC{16'd100}};
        foreach (m_drop[i]) m_drop[i] = 0;
        m_trunc = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_tready", int'(s_if.tready), 1);
        check("reset_tvalid", int'(m_if.tvalid), 0);
        m_if.tready = 1'b0;
        #1 check("reset_tready_follow", int'(s_if.tready), 0);
        m_if.tready = 1'b1;
        @(posedge clk);
        #1 check_counts();

        // Whole 64-beat class-2 frame dropped at level == threshold.
        threshold[2*LW +: LW] = 16'd10;
        drop_enable = 4'b0100;
        fill(64, 10, 10);
        send_frame(64, 2, 0, 0, cyc);
        check_counts();
        gap(2, 0);

        // Level 9 passes; rise to 20 mid-frame changes nothing with truncate off.
        fill(64, 9, 9);
        for (int i = 32; i < 64; i++) lvl_a[i] = 20;
        send_frame(64, 2, 1, 0, cyc);
        gap(2, 0);
        check_counts();

        // Truncation at hard limit from beat 5, then a normal frame.
        truncate_enable = 1'b1;
        hard_limit = 16'd30;
        fill(20, 9, 9);
        for (int i = 5; i < 20; i++) lvl_a[i] = 30;
        send_frame(20, 2, 0, 0, cyc);
        fill(4, 9, 9);
        send_frame(4, 2, 0, 0, cyc);
        gap(2, 0);
        check_counts();
        truncate_enable = 1'b0;

        // Stall on the first pass beat while the level crosses the threshold.
        fill(6, 8, 8);
        send_frame(6, 2, 0, 3, cyc);
        gap(2, 0);
        check_counts();

        // Back-to-back single-beat frames; tdest=7 clamps to class 3.
        drop_enable = 4'b1111;
        threshold = {16'd5, 16'd100, 16'd100, 16'd100};
        for (int f = 0; f < 8; f++) begin
            fill(1, (f % 2 == 0) ? 5 : 4, (f % 2 == 0) ? 5 : 4);
            send_frame(1, 7, 0, 0, cyc);
            check("no_bubble", cyc, 1);
        end
        gap(2, 0);
        check_counts();

        // Saturation of drop_count[0], then clear colliding with a drop.
        threshold[0 +: LW] = 16'd0;
        for (int f = 0; f < 18; f++) begin
            fill(1, 0, 3);
            send_frame(1, 0, 0, 0, cyc);
        end
        check_counts();
        stats_clear = 1'b1;
        fill(1, 0, 3);
        send_frame(1, 0, 0, 0, cyc);
        stats_clear = 1'b0;
        foreach (m_drop[i]) m_drop[i] = 0;
        m_trunc = 0;
        check_counts();

        // Randomized frames with random ready, thresholds and truncation.
        for (int f = 0; f < 40; f++) begin
            drop_enable = 4'($urandom_range(0, 15));
            for (int k = 0; k < NC; k++) threshold[k*LW +: LW] = 16'($urandom_range(0, 40));
            hard_limit = 16'($urandom_range(10, 40));
            truncate_enable = 1'($urandom_range(0, 1));
            fill($urandom_range(1, 12) + 0, 0, 45);
            send_frame($urandom_range(1, 12), $urandom_range(0, 7), 1, 0, cyc);
            gap($urandom_range(0, 2), 1);
            check_counts();
        end

        gap(5, 0);
        check("leftover_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
